// File: rtl/spart_pkg.sv
// Shared SPART definitions: frame defaults and the receive state encoding.
package spart_pkg;

  localparam int unsigned SpartDataBits   = 8;
  localparam int unsigned SpartOversample = 16;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous level; resets to 1 (line idle).
module rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 8N1 deserializer driven by the 16x oversample tick, with rda/frame/overrun flags.
module spart_rx
  import spart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = SpartDataBits,
  parameter int unsigned OVERSAMPLE = SpartOversample
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rxd,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW  = $clog2(DATA_BITS);

  localparam logic [TickW-1:0] TickMid = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickEnd = TickW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0]  IdxEnd  = IdxW'(DATA_BITS - 1);

  logic rxd_s;

  rx_sync u_rxd_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (rxd),
    .q_o    (rxd_s)
  );

  rx_state_e            state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rda_q, rda_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    rda_d   = rda_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (rd_ack) begin
      rda_d = 1'b0;
      ovr_d = 1'b0;
    end

    if (en) begin
      unique case (state_q)
        RxIdle: begin
          if (!rxd_s) begin
            state_d = RxStart;
            tick_d  = '0;
          end
        end
        RxStart: begin
          if (tick_q == TickMid) begin
            // Line back high at mid-start means a glitch, not a start bit.
            state_d = rxd_s ? RxIdle : RxData;
            tick_d  = '0;
            idx_d   = '0;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        RxData: begin
          if (tick_q == TickEnd) begin
            tick_d  = '0;
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + IdxW'(1);
            if (idx_q == IdxEnd) begin
              state_d = RxStop;
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        RxStop: begin
          if (tick_q == TickEnd) begin
            tick_d  = '0;
            data_d  = shift_q;
            ferr_d  = ~rxd_s;
            rda_d   = 1'b1;
            // An ack landing with the load consumes the old byte, so no overrun.
            ovr_d   = rd_ack ? 1'b0 : (ovr_q | rda_q);
            state_d = RxIdle;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        default: state_d = RxIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RxIdle;
      tick_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rda_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rda_q   <= rda_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rda       = rda_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: en every 4 clk, one bit = 64 clk, frames driven on negedges.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rxd;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rda;
  logic       frame_err;
  logic       overrun;

  int unsigned edge_n = 0;
  int unsigned npass  = 0;
  int unsigned ntot   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // en is high for every posedge whose index is a multiple of 4.
  initial begin
    en = 1'b0;
    forever begin
      @(negedge clk);
      en = ((edge_n + 1) % 4 == 0);
    end
  end

  spart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rxd       (rxd),
    .rd_ack    (rd_ack),
    .rx_data   (rx_data),
    .rda       (rda),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Start bit begins on a negedge just before an edge index 4m+1, so the start
  // is detected at relative edge 4 and the stop sample lands on relative edge 612.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int ack_at,
                            input int abort_at, input bit chk_lat);
    int b;
    do @(negedge clk); while (edge_n % 4 != 0);
    for (int i = 0; i < 640; i++) begin
      if (i > 0) @(negedge clk);
      if (i == abort_at) begin
        rst    = 1'b0;
        rd_ack = 1'b0;
        #1;
        check("abort_rx_data", rx_data, 0);
        check("abort_rda", rda, 0);
        check("abort_frame_err", frame_err, 0);
        check("abort_overrun", overrun, 0);
        rxd = 1'b1;
        return;
      end
      b = i / 64;
      rxd    = (b == 0) ? 1'b0 : (b == 9) ? stop : data[b-1];
      rd_ack = (i == ack_at);
      if (chk_lat && i == 611) check("rda_before_stop_sample", rda, 0);
      if (chk_lat && i == 612) check("rda_at_stop_sample", rda, 1);
    end
    rd_ack = 1'b0;
  endtask

  initial begin
    rst    = 1'b0;
    rxd    = 1'b1;
    rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 0);
    check("reset_rda", rda, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b1;
    idle(20);

    // Good frame with exact stop-sample timing.
    send_frame(8'hA5, 1'b1, -1, -1, 1'b1);
    check("a5_rx_data", rx_data, 8'hA5);
    check("a5_rda", rda, 1);
    check("a5_frame_err", frame_err, 0);
    check("a5_overrun", overrun, 0);
    idle(10);
    pulse_ack();
    check("ack_clears_rda", rda, 0);

    // Start glitch of 3 en ticks is rejected.
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    idle(800);
    check("glitch_rda", rda, 0);
    check("glitch_rx_data", rx_data, 8'hA5);

    // Framing error, then a clean frame clears it.
    send_frame(8'h3C, 1'b0, -1, -1, 1'b0);
    check("ferr_rx_data", rx_data, 8'h3C);
    check("ferr_rda", rda, 1);
    check("ferr_flag", frame_err, 1);
    idle(100);
    pulse_ack();
    send_frame(8'h01, 1'b1, -1, -1, 1'b0);
    check("good_after_ferr_rx_data", rx_data, 8'h01);
    check("good_after_ferr_flag", frame_err, 0);
    idle(10);
    pulse_ack();

    // Overrun when a second frame lands unread.
    send_frame(8'h11, 1'b1, -1, -1, 1'b0);
    check("first_no_overrun", overrun, 0);
    send_frame(8'h22, 1'b1, -1, -1, 1'b0);
    check("overrun_rx_data", rx_data, 8'h22);
    check("overrun_rda", rda, 1);
    check("overrun_flag", overrun, 1);
    pulse_ack();
    check("ack_rda", rda, 0);
    check("ack_overrun", overrun, 0);

    // rd_ack coincident with a load: load wins, no overrun.
    send_frame(8'h33, 1'b1, -1, -1, 1'b0);
    check("pre_coinc_rda", rda, 1);
    send_frame(8'h5A, 1'b1, 611, -1, 1'b0);
    check("coinc_rx_data", rx_data, 8'h5A);
    check("coinc_rda", rda, 1);
    check("coinc_overrun", overrun, 0);

    // Reset during data bit 4 aborts the frame.
    send_frame(8'h96, 1'b1, -1, 350, 1'b0);
    idle(5);
    rst = 1'b1;
    idle(20);
    send_frame(8'hC3, 1'b1, -1, -1, 1'b0);
    check("post_reset_rx_data", rx_data, 8'hC3);
    check("post_reset_rda", rda, 1);
    check("post_reset_frame_err", frame_err, 0);
    pulse_ack();

    // Back-to-back frames with no idle gap, acked during each stop bit.
    send_frame(8'h00, 1'b1, 630, -1, 1'b0);
    check("b2b0_rx_data", rx_data, 8'h00);
    check("b2b0_rda", rda, 0);
    check("b2b0_frame_err", frame_err, 0);
    send_frame(8'hFF, 1'b1, 630, -1, 1'b0);
    check("b2b1_rx_data", rx_data, 8'hFF);
    check("b2b1_rda", rda, 0);
    check("b2b1_frame_err", frame_err, 0);
    check("b2b1_overrun", overrun, 0);

    idle(10);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
